// File: rtl/fft_pkg.sv
// Shared FFT constants: default widths and the rounding constant.
// Imported by the butterfly top and the complex multiplier.
package fft_pkg;
  localparam int PORT_WIDTH = 16;
  localparam int FRAC_BITS  = PORT_WIDTH - 2;

  function automatic longint rnd_const(int fb);
    return longint'(1) <<< (fb - 1);
  endfunction

  localparam longint RND_DEFAULT = rnd_const(FRAC_BITS);
endpackage

// File: rtl/cmplx_mult.sv
// Butterfly stages S2 (four real products) and S3 (combine/round/sat).
// en holds every register; sat_hit flags a saturating result being loaded.
module cmplx_mult
  import fft_pkg::*;
#(
  parameter int portWidth = PORT_WIDTH,
  parameter int fracBits  = portWidth - 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic signed [portWidth-1:0] d_r,
  input  logic signed [portWidth-1:0] d_i,
  input  logic signed [portWidth-1:0] w_r,
  input  logic signed [portWidth-1:0] w_i,
  input  logic signed [portWidth-1:0] s_r,
  input  logic signed [portWidth-1:0] s_i,
  output logic                        out_valid,
  output logic signed [portWidth-1:0] out1_r,
  output logic signed [portWidth-1:0] out1_i,
  output logic signed [portWidth-1:0] out2_r,
  output logic signed [portWidth-1:0] out2_i,
  output logic                        sat_hit
);
  localparam int W = portWidth;
  localparam int P = 2 * W;
  localparam int A = P + 2;

  localparam longint HI_L = (longint'(1) <<< (W - 1)) - 1;
  localparam longint LO_L = -(longint'(1) <<< (W - 1));

  localparam logic signed [A-1:0] HI  = A'(HI_L);
  localparam logic signed [A-1:0] LO  = A'(LO_L);
  localparam logic signed [A-1:0] RND = A'(rnd_const(fracBits));

  logic                v2;
  logic signed [P-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [W-1:0] s2_r, s2_i;

  logic signed [A-1:0] re, im, re_sh, im_sh;
  logic signed [W-1:0] re_q, im_q;
  logic                sat_r, sat_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2   <= 1'b0;
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
      s2_r <= '0;
      s2_i <= '0;
    end else if (en) begin
      v2   <= in_valid;
      p_rr <= P'(d_r) * P'(w_r);
      p_ii <= P'(d_i) * P'(w_i);
      p_ri <= P'(d_r) * P'(w_i);
      p_ir <= P'(d_i) * P'(w_r);
      s2_r <= s_r;
      s2_i <= s_i;
    end
  end

  // Two guard bits above the product width keep the rounding add exact.
  always_comb begin
    re    = A'(p_rr) - A'(p_ii);
    im    = A'(p_ri) + A'(p_ir);
    re_sh = (re + RND) >>> fracBits;
    im_sh = (im + RND) >>> fracBits;
    sat_r = (re_sh > HI) || (re_sh < LO);
    sat_i = (im_sh > HI) || (im_sh < LO);
    re_q  = re_sh[W-1:0];
    im_q  = im_sh[W-1:0];
    if (re_sh > HI) re_q = HI[W-1:0];
    if (re_sh < LO) re_q = LO[W-1:0];
    if (im_sh > HI) im_q = HI[W-1:0];
    if (im_sh < LO) im_q = LO[W-1:0];
  end

  assign sat_hit = en && v2 && (sat_r || sat_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out1_r    <= '0;
      out1_i    <= '0;
      out2_r    <= '0;
      out2_i    <= '0;
    end else if (en) begin
      out_valid <= v2;
      out1_r    <= s2_r;
      out1_i    <= s2_i;
      out2_r    <= re_q;
      out2_i    <= im_q;
    end
  end
endmodule

// File: rtl/dif_butterfly.sv
// Radix-2 DIF butterfly: Out1=(a+b)/2, Out2=((a-b)/2)*W, 3-stage pipe.
// Global stall on output backpressure; sticky satFlag with satClear.
module dif_butterfly
  import fft_pkg::*;
#(
  parameter int portWidth = PORT_WIDTH,
  parameter int fracBits  = portWidth - 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [portWidth-1:0] bflyIn1R,
  input  logic signed [portWidth-1:0] bflyIn1I,
  input  logic signed [portWidth-1:0] bflyIn2R,
  input  logic signed [portWidth-1:0] bflyIn2I,
  input  logic signed [portWidth-1:0] bflyWr,
  input  logic signed [portWidth-1:0] bflyWi,
  input  logic                        inValid,
  output logic                        inReady,
  output logic signed [portWidth-1:0] bflyOut1R,
  output logic signed [portWidth-1:0] bflyOut1I,
  output logic signed [portWidth-1:0] bflyOut2R,
  output logic signed [portWidth-1:0] bflyOut2I,
  output logic                        outValid,
  input  logic                        outReady,
  output logic                        satFlag,
  input  logic                        satClear
);
  localparam int W = portWidth;

  logic              stall, en, sat_hit;
  logic signed [W:0] sum_r, sum_i, dif_r, dif_i;

  logic                v1;
  logic signed [W-1:0] s1_sr, s1_si, s1_dr, s1_di;
  logic signed [W-1:0] s1_wr, s1_wi;

  assign stall   = outValid && !outReady;
  assign en      = !stall;
  assign inReady = en;

  assign sum_r = (W+1)'(bflyIn1R) + (W+1)'(bflyIn2R);
  assign sum_i = (W+1)'(bflyIn1I) + (W+1)'(bflyIn2I);
  assign dif_r = (W+1)'(bflyIn1R) - (W+1)'(bflyIn2R);
  assign dif_i = (W+1)'(bflyIn1I) - (W+1)'(bflyIn2I);

  // Halving by arithmetic shift always brings W+1 bits back into W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1    <= 1'b0;
      s1_sr <= '0;
      s1_si <= '0;
      s1_dr <= '0;
      s1_di <= '0;
      s1_wr <= '0;
      s1_wi <= '0;
    end else if (en) begin
      v1    <= inValid;
      s1_sr <= W'(sum_r >>> 1);
      s1_si <= W'(sum_i >>> 1);
      s1_dr <= W'(dif_r >>> 1);
      s1_di <= W'(dif_i >>> 1);
      s1_wr <= bflyWr;
      s1_wi <= bflyWi;
    end
  end

  cmplx_mult #(
    .portWidth(W),
    .fracBits (fracBits)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (v1),
    .d_r      (s1_dr),
    .d_i      (s1_di),
    .w_r      (s1_wr),
    .w_i      (s1_wi),
    .s_r      (s1_sr),
    .s_i      (s1_si),
    .out_valid(outValid),
    .out1_r   (bflyOut1R),
    .out1_i   (bflyOut1I),
    .out2_r   (bflyOut2R),
    .out2_i   (bflyOut2I),
    .sat_hit  (sat_hit)
  );

  // A new saturation wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          satFlag <= 1'b0;
    else if (sat_hit)  satFlag <= 1'b1;
    else if (satClear) satFlag <= 1'b0;
  end
endmodule
